merge_ctrl: RTL

- Two-way merge scheduler for the parallel sort datapath; sits between two sorted-run input FIFOs (A, B) and the next merge stage.
- Compares the head words of both FIFOs, issues a read strobe to exactly one FIFO per accepted word, and emits a merged run of length 2*RUN_LEN.
- Runs are delimited by counting only; there are no in-band markers. Downstream backpressure is handled through a one-entry registered output stage.

---
 rtl/merge_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/merge_ctrl.sv
// Two-way merge scheduler: pops the winning head of two sorted-run FIFOs into a
// one-entry output register and emits merged runs of 2*RUN_LEN words.
module merge_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int RUN_LEN    = 4,
   parameter bit ASCENDING  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] head_a,
   input  logic                  empty_a,
   input  logic [DATA_WIDTH-1:0] head_b,
   input  logic                  empty_b,
   output logic                  rd_en_a,
   output logic                  rd_en_b,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  run_done
);

   localparam int CW = $clog2(RUN_LEN) + 1;
   localparam logic [CW-1:0] RUN_MAX   = CW'(RUN_LEN);
   localparam logic [CW:0]   RUN_TOTAL = (CW+1)'(2 * RUN_LEN);

   localparam logic [1:0] ST_MERGE   = 2'd0;
   localparam logic [1:0] ST_DRAIN_A = 2'd1;
   localparam logic [1:0] ST_DRAIN_B = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  run_done_q, run_done_d;

   logic                  slot_free, a_wins, pop_a, pop_b, run_end;
   logic [CW-1:0]         cnt_a_inc, cnt_b_inc;

   // Pop decision: the output slot must be free, and in MERGE both heads must be
   // present so the comparison is meaningful. Ties go to A.
   always_comb begin
      slot_free = !out_valid_q || out_ready;
      a_wins    = ASCENDING ? (head_a <= head_b) : (head_a >= head_b);
      pop_a     = 1'b0;
      pop_b     = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_MERGE: begin
               if (slot_free && !empty_a && !empty_b) begin
                  pop_a = a_wins;
                  pop_b = !a_wins;
               end
            end
            ST_DRAIN_A: pop_a = slot_free && !empty_a;
            ST_DRAIN_B: pop_b = slot_free && !empty_b;
            default: ;
         endcase
      end
   end

   always_comb begin
      cnt_a_inc = cnt_a_q + CW'(pop_a);
      cnt_b_inc = cnt_b_q + CW'(pop_b);
      run_end   = (pop_a || pop_b) &&
                  (({1'b0, cnt_a_inc} + {1'b0, cnt_b_inc}) == RUN_TOTAL);

      state_d = state_q;
      cnt_a_d = cnt_a_inc;
      cnt_b_d = cnt_b_inc;
      if (run_end) begin
         state_d = ST_MERGE;
         cnt_a_d = '0;
         cnt_b_d = '0;
      end else begin
         case (state_q)
            ST_MERGE: begin
               if (cnt_a_inc == RUN_MAX) begin
                  state_d = ST_DRAIN_B;
               end else if (cnt_b_inc == RUN_MAX) begin
                  state_d = ST_DRAIN_A;
               end
            end
            ST_DRAIN_A, ST_DRAIN_B: ;
            default: state_d = ST_MERGE;
         endcase
      end

      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (pop_a || pop_b) begin
         out_data_d  = pop_a ? head_a : head_b;
         out_valid_d = 1'b1;
         out_last_d  = run_end;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      run_done_d = run_end;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_MERGE;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         run_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         run_done_q  <= run_done_d;
      end
   end

   assign rd_en_a   = pop_a;
   assign rd_en_b   = pop_b;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign run_done  = run_done_q;

endmodule
